// File: rtl/fetch_prefetch_queue_if.sv
// Handshake bundle between the fetch stage, instruction memory, redirect source and decode.
// The slave modport is the fetch stage; the master modport is everything around it.
interface fetch_prefetch_queue_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redir_valid;
    logic [ADDR_W-1:0]  redir_pc;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic [ADDR_W-1:0]  out_pc_next;
    logic [CNT_W-1:0]   occupancy;

    modport slave (
        output imem_req, imem_addr,
        input  imem_rdata,
        input  redir_valid, redir_pc,
        output out_valid, out_instr, out_pc, out_pc_next, occupancy,
        input  out_ready
    );

    modport master (
        input  imem_req, imem_addr,
        output imem_rdata,
        output redir_valid, redir_pc,
        input  out_valid, out_instr, out_pc, out_pc_next, occupancy,
        output out_ready
    );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Fetch stage with a DEPTH-entry prefetch queue; runs ahead of decode, flushes on redirect.
// Memory responses arrive one cycle after the request and land at the queue tail.
module fetch_prefetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_INC   = 1
) (
    input logic                  clk_i,
    input logic                  rst_n_i,
    fetch_prefetch_queue_if.slave bus
);
    localparam int                CNT_W    = $clog2(DEPTH + 1);
    localparam int                PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W:0]    DEPTH_C  = (CNT_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] INC_C    = ADDR_W'(PC_INC);

    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]  req_pc_q,   req_pc_d;
    logic               inflight_q, inflight_d;
    logic [PTR_W-1:0]   head_q,     head_d;
    logic [PTR_W-1:0]   tail_q,     tail_d;
    logic [CNT_W-1:0]   count_q,    count_d;

    logic [INSTR_W-1:0] instr_mem_q [DEPTH];
    logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];

    logic [CNT_W:0]     credit;
    logic               req;
    logic               push;
    logic               pop;
    logic               not_empty;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Credit counts the response still in flight but takes nothing back for a same-cycle pop,
    // so a write can never land on a full queue. Requests are held off while in reset.
    always_comb begin
        not_empty  = (count_q != '0);
        credit     = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
        req        = rst_n_i && !bus.redir_valid && (credit < DEPTH_C);
        push       = inflight_q && !bus.redir_valid;
        pop        = not_empty && bus.out_ready;

        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = req;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        if (req) begin
            fetch_pc_d = fetch_pc_q + INC_C;
            req_pc_d   = fetch_pc_q;
        end

        if (bus.redir_valid) begin
            fetch_pc_d = bus.redir_pc;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (push) tail_d = ptr_next(tail_q);
            if (pop)  head_d = ptr_next(head_q);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Payload storage needs no reset: count_q alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_mem_q[tail_q] <= bus.imem_rdata;
            pc_mem_q[tail_q]    <= req_pc_q;
        end
    end

    assign bus.imem_req    = req;
    assign bus.imem_addr   = fetch_pc_q;
    assign bus.out_valid   = not_empty;
    assign bus.out_instr   = instr_mem_q[head_q];
    assign bus.out_pc      = pc_mem_q[head_q];
    assign bus.out_pc_next = pc_mem_q[head_q] + INC_C;
    assign bus.occupancy   = count_q;
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench: a DEPTH=4 fetch stage driven from a per-cycle vector table, plus a DEPTH=2 build
// used for the address-wrap and reduced-throughput sequence.
module tb_fetch_prefetch_queue;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    fetch_prefetch_queue_if #(.ADDR_W(32), .INSTR_W(16), .DEPTH(4)) if4 ();
    fetch_prefetch_queue_if #(.ADDR_W(32), .INSTR_W(16), .DEPTH(2)) if2 ();

    fetch_prefetch_queue #(.ADDR_W(32), .INSTR_W(16), .DEPTH(4), .RESET_PC(32'h0), .PC_INC(1))
        dut4 (.clk_i(clk), .rst_n_i(rst_n), .bus(if4));
    fetch_prefetch_queue #(.ADDR_W(32), .INSTR_W(16), .DEPTH(2), .RESET_PC(32'h0), .PC_INC(1))
        dut2 (.clk_i(clk), .rst_n_i(rst_n), .bus(if2));

    function automatic logic [15:0] mem_word(input logic [31:0] a);
        return 16'(a[15:0] + a[31:16]) ^ 16'hA5C3;
    endfunction

    // Instruction memory models: data one cycle after an accepted request, junk otherwise.
    always @(posedge clk) if4.imem_rdata <= if4.imem_req ? mem_word(if4.imem_addr) : 16'hDEAD;
    always @(posedge clk) if2.imem_rdata <= if2.imem_req ? mem_word(if2.imem_addr) : 16'hDEAD;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [2:0]  e_occ;
    } vec_t;

    function automatic vec_t v(input logic redir, input logic [31:0] rpc, input logic rdy,
                               input logic e_req, input logic [31:0] e_addr,
                               input logic e_valid, input logic [31:0] e_pc, input logic [2:0] e_occ);
        vec_t r;
        r.redir = redir; r.rpc = rpc; r.rdy = rdy;
        r.e_req = e_req; r.e_addr = e_addr;
        r.e_valid = e_valid; r.e_pc = e_pc; r.e_occ = e_occ;
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vt[$];
        int   n;
        logic [31:0] exp_pc;

        // streaming from reset, 10-cycle stall, redirect with full credit, back-to-back redirects
        vt.push_back(v(0, 0, 1, 1, 32'h00, 0, 0, 0));
        vt.push_back(v(0, 0, 1, 1, 32'h01, 0, 0, 0));
        vt.push_back(v(0, 0, 1, 1, 32'h02, 1, 32'h0, 1));
        vt.push_back(v(0, 0, 1, 1, 32'h03, 1, 32'h1, 1));
        vt.push_back(v(0, 0, 1, 1, 32'h04, 1, 32'h2, 1));
        vt.push_back(v(0, 0, 0, 1, 32'h05, 1, 32'h3, 1));
        vt.push_back(v(0, 0, 0, 1, 32'h06, 1, 32'h3, 2));
        vt.push_back(v(0, 0, 0, 0, 32'h07, 1, 32'h3, 3));
        for (int k = 0; k < 7; k++) vt.push_back(v(0, 0, 0, 0, 32'h07, 1, 32'h3, 4));
        vt.push_back(v(0, 0, 1, 0, 32'h07, 1, 32'h3, 4));
        vt.push_back(v(0, 0, 1, 1, 32'h07, 1, 32'h4, 3));
        vt.push_back(v(0, 0, 1, 1, 32'h08, 1, 32'h5, 2));
        vt.push_back(v(0, 0, 1, 1, 32'h09, 1, 32'h6, 2));
        vt.push_back(v(0, 0, 1, 1, 32'h0A, 1, 32'h7, 2));
        vt.push_back(v(0, 0, 1, 1, 32'h0B, 1, 32'h8, 2));
        vt.push_back(v(0, 0, 0, 1, 32'h0C, 1, 32'h9, 2));
        vt.push_back(v(1, 32'h40, 0, 0, 32'h0D, 1, 32'h9, 3));
        vt.push_back(v(0, 0, 1, 1, 32'h40, 0, 0, 0));
        vt.push_back(v(0, 0, 1, 1, 32'h41, 0, 0, 0));
        vt.push_back(v(0, 0, 1, 1, 32'h42, 1, 32'h40, 1));
        vt.push_back(v(1, 32'h10, 1, 0, 32'h43, 1, 32'h41, 1));
        vt.push_back(v(1, 32'h80, 1, 0, 32'h10, 0, 0, 0));
        vt.push_back(v(0, 0, 1, 1, 32'h80, 0, 0, 0));
        vt.push_back(v(0, 0, 1, 1, 32'h81, 0, 0, 0));
        vt.push_back(v(0, 0, 1, 1, 32'h82, 1, 32'h80, 1));

        rst_n = 1'b0;
        if4.redir_valid = 1'b0; if4.redir_pc = '0; if4.out_ready = 1'b1;
        if2.redir_valid = 1'b0; if2.redir_pc = '0; if2.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset req",   64'(if4.imem_req),  64'(0));
        chk("reset valid", 64'(if4.out_valid), 64'(0));
        chk("reset occ",   64'(if4.occupancy), 64'(0));
        chk("reset d2 req", 64'(if2.imem_req), 64'(0));

        foreach (vt[i]) begin
            @(negedge clk);
            if (i == 0) rst_n = 1'b1;
            if4.redir_valid = vt[i].redir;
            if4.redir_pc    = vt[i].rpc;
            if4.out_ready   = vt[i].rdy;
            #1;
            chk($sformatf("v%0d req", i),   64'(if4.imem_req),  64'(vt[i].e_req));
            chk($sformatf("v%0d addr", i),  64'(if4.imem_addr), 64'(vt[i].e_addr));
            chk($sformatf("v%0d valid", i), 64'(if4.out_valid), 64'(vt[i].e_valid));
            chk($sformatf("v%0d occ", i),   64'(if4.occupancy), 64'(vt[i].e_occ));
            if (vt[i].e_valid) begin
                chk($sformatf("v%0d pc", i),    64'(if4.out_pc),      64'(vt[i].e_pc));
                chk($sformatf("v%0d pcnx", i),  64'(if4.out_pc_next), 64'(vt[i].e_pc + 32'd1));
                chk($sformatf("v%0d instr", i), 64'(if4.out_instr),   64'(mem_word(vt[i].e_pc)));
            end
        end

        // fill the queue, then reset asynchronously in the middle of a cycle
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if4.redir_valid = 1'b0;
            if4.out_ready   = 1'b0;
        end
        #1;
        chk("full occ", 64'(if4.occupancy), 64'(4));
        chk("full req", 64'(if4.imem_req),  64'(0));
        rst_n = 1'b0;
        #1;
        chk("async rst valid", 64'(if4.out_valid), 64'(0));
        chk("async rst req",   64'(if4.imem_req),  64'(0));
        chk("async rst occ",   64'(if4.occupancy), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        if4.out_ready = 1'b1;
        #1;
        chk("restart req",  64'(if4.imem_req),  64'(1));
        chk("restart addr", 64'(if4.imem_addr), 64'(0));
        @(negedge clk);
        #1;
        chk("restart addr1", 64'(if4.imem_addr), 64'(1));
        chk("restart valid0", 64'(if4.out_valid), 64'(0));
        @(negedge clk);
        #1;
        chk("restart valid", 64'(if4.out_valid), 64'(1));
        chk("restart pc",    64'(if4.out_pc),    64'(0));
        chk("restart instr", 64'(if4.out_instr), 64'(mem_word(32'h0)));

        // DEPTH=2 build: redirect to the top of the address space and follow the wrap
        @(negedge clk);
        if2.redir_valid = 1'b1;
        if2.redir_pc    = 32'hFFFF_FFFF;
        #1;
        chk("d2 redir req", 64'(if2.imem_req), 64'(0));
        @(negedge clk);
        if2.redir_valid = 1'b0;
        #1;
        chk("d2 first req",  64'(if2.imem_req),  64'(1));
        chk("d2 first addr", 64'(if2.imem_addr), 64'(32'hFFFF_FFFF));
        n = 0;
        for (int c = 0; c < 14 && n < 6; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("d2 occ bound c%0d", c), 64'(if2.occupancy <= 2'd2), 64'(1));
            if (if2.out_valid) begin
                exp_pc = 32'hFFFF_FFFF + 32'(n);
                chk($sformatf("d2 pc%0d", n),    64'(if2.out_pc),    64'(exp_pc));
                chk($sformatf("d2 instr%0d", n), 64'(if2.out_instr), 64'(mem_word(exp_pc)));
                n++;
            end
        end
        chk("d2 pops in budget", 64'(n), 64'(6));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
